// File: rtl/uartlite_axi_arbiter.sv
// uartlite_axi_arbiter: two-requester round-robin arbiter driving one AXI4-Lite
// master port toward an axi_uartlite. Single outstanding transaction.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort stalled transactions
// with SLVERR after TIMEOUT cycles.
module uartlite_axi_arbiter #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req1_valid,
    input  logic              req0_write,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              req0_done,
    output logic              req1_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [1:0]        req0_resp,
    output logic [1:0]        req1_resp,
    output logic [ADDR_W-1:0] AW_addr,
    output logic              AW_valid,
    input  logic              AW_ready,
    output logic [DATA_W-1:0] W_data,
    output logic [3:0]        W_strobe,
    output logic              W_valid,
    input  logic              W_ready,
    input  logic [1:0]        B_resp,
    input  logic              B_valid,
    output logic              B_ready,
    output logic [ADDR_W-1:0] AR_addr,
    output logic              AR_valid,
    input  logic              AR_ready,
    input  logic [DATA_W-1:0] R_data,
    input  logic [1:0]        R_resp,
    input  logic              R_valid,
    output logic              R_ready,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE
    } state_t;

    state_t            r_state, w_next;
    logic              r_grant, r_last, r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_aw_pend, r_w_pend;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;
    logic [1:0]        r_resp0, r_resp1;

    logic              w_any, w_sel, w_take, w_cap, w_tmo_hit;
    logic [DATA_W-1:0] w_cap_data;
    logic [1:0]        w_cap_resp;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;

    // Watchdog counts cycles spent waiting on the slave; cleared while idle
    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE) r_tmo_cnt <= '0;
        else if (r_state != DONE)   r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end

    assign w_tmo_hit = (r_state != IDLE) && (r_state != DONE) &&
                       (r_tmo_cnt >= 32'(TIMEOUT - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Round-robin pick: on contention the requester not served last wins
    assign w_any = req0_valid | req1_valid;
    assign w_sel = (req0_valid && req1_valid) ? ~r_last : req1_valid;

    // Next-state, grant acceptance and response capture
    always_comb begin
        w_next     = r_state;
        w_take     = 1'b0;
        w_cap      = 1'b0;
        w_cap_data = '0;
        w_cap_resp = 2'b00;
        unique case (r_state)
            IDLE: if (w_any && !rst) begin
                w_take = 1'b1;
                w_next = (w_sel ? req1_write : req0_write) ? WR_ADDR : RD_ADDR;
            end
            RD_ADDR: begin
                if (AR_ready)       w_next = RD_DATA;
                else if (w_tmo_hit) begin w_next = DONE; w_cap = 1'b1; w_cap_resp = 2'b10; end
            end
            RD_DATA: begin
                if (R_valid) begin
                    w_next = DONE; w_cap = 1'b1; w_cap_data = R_data; w_cap_resp = R_resp;
                end else if (w_tmo_hit) begin
                    w_next = DONE; w_cap = 1'b1; w_cap_resp = 2'b10;
                end
            end
            WR_ADDR: begin
                if ((!r_aw_pend || AW_ready) && (!r_w_pend || W_ready)) w_next = WR_RESP;
                else if (w_tmo_hit) begin w_next = DONE; w_cap = 1'b1; w_cap_resp = 2'b10; end
            end
            WR_RESP: begin
                if (B_valid) begin
                    w_next = DONE; w_cap = 1'b1; w_cap_resp = B_resp;
                end else if (w_tmo_hit) begin
                    w_next = DONE; w_cap = 1'b1; w_cap_resp = 2'b10;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register, latched command and per-requester results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_resp0   <= 2'b00;
            r_resp1   <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_grant   <= w_sel;
                r_write   <= w_sel ? req1_write : req0_write;
                r_addr    <= w_sel ? req1_addr  : req0_addr;
                r_wdata   <= w_sel ? req1_wdata : req0_wdata;
                r_aw_pend <= 1'b1;
                r_w_pend  <= 1'b1;
            end else if (r_state == WR_ADDR) begin
                if (AW_ready) r_aw_pend <= 1'b0;
                if (W_ready)  r_w_pend  <= 1'b0;
            end
            if (w_cap && !r_grant) begin r_rdata0 <= w_cap_data; r_resp0 <= w_cap_resp; end
            if (w_cap &&  r_grant) begin r_rdata1 <= w_cap_data; r_resp1 <= w_cap_resp; end
            if (r_state == DONE) r_last <= r_grant;
        end
    end

    assign req0_ready = w_take && !w_sel;
    assign req1_ready = w_take &&  w_sel;
    assign req0_done  = (r_state == DONE) && !r_grant;
    assign req1_done  = (r_state == DONE) &&  r_grant;
    assign req0_rdata = r_rdata0;
    assign req1_rdata = r_rdata1;
    assign req0_resp  = r_resp0;
    assign req1_resp  = r_resp1;

    assign AW_addr  = r_addr;
    assign AR_addr  = r_addr;
    assign W_data   = r_wdata;
    assign W_strobe = 4'b1111;
    assign AW_valid = (r_state == WR_ADDR) && r_aw_pend;
    assign W_valid  = (r_state == WR_ADDR) && r_w_pend;
    assign B_ready  = (r_state == WR_RESP);
    assign AR_valid = (r_state == RD_ADDR);
    assign R_ready  = (r_state == RD_DATA);
    assign busy     = (r_state != IDLE);
    assign grant_id = r_grant;

endmodule

// File: doc/uartlite_axi_arbiter.md
# uartlite_axi_arbiter

Two-requester, round-robin arbiter sharing one AXI4-Lite master port to a single `axi_uartlite` instance (GPS or FTDI side). Each requester issues single-beat register reads/writes over a simple valid/ready command port and receives a one-cycle completion pulse. The arbiter sequences the AXI channels itself, so no more than one transaction is ever outstanding.

## Interface
Parameters:
- `ADDR_W`, 4, AXI address width (UART Lite register offsets 0x0/0x4/0x8/0xC).
- `DATA_W`, 32, AXI data width.
- `TIMEOUT`, 255, watchdog limit in cycles; used only with `UART_ARB_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: command request.
- `req0_write`, `req1_write` in 1: 1 = write, 0 = read.
- `req0_addr`, `req1_addr` in ADDR_W: register offset.
- `req0_wdata`, `req1_wdata` in DATA_W: write data.
- `req0_ready`, `req1_ready` out 1: command accepted (1-cycle pulse).
- `req0_done`, `req1_done` out 1: completion (1-cycle pulse).
- `req0_rdata`, `req1_rdata` out DATA_W: read data, valid on done.
- `req0_resp`, `req1_resp` out 2: AXI response, valid on done.
- `AW_addr` out ADDR_W, `AW_valid` out 1, `AW_ready` in 1.
- `W_data` out DATA_W, `W_strobe` out 4 (constant 4'b1111), `W_valid` out 1, `W_ready` in 1.
- `B_resp` in 2, `B_valid` in 1, `B_ready` out 1.
- `AR_addr` out ADDR_W, `AR_valid` out 1, `AR_ready` in 1.
- `R_data` in DATA_W, `R_resp` in 2, `R_valid` in 1, `R_ready` out 1.
- `busy` out 1: FSM not in IDLE.
- `grant_id` out 1: requester currently owning the port.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE.
- IDLE: if only one `reqN_valid` is high, grant it. If both are high, grant the requester not granted last (`last_grant`). Pulse `reqN_ready`, latch write/addr/wdata, set `grant_id`, then go to RD_ADDR or WR_ADDR.
- RD_ADDR: `AR_valid`=1 with the latched addr. On `AR_ready`, go to RD_DATA.
- RD_DATA: `R_ready`=1. On `R_valid`, latch `R_data`/`R_resp`, go to DONE.
- WR_ADDR: `AW_valid` and `W_valid` are both raised on entry. Each drops independently on its own handshake. Once both handshakes are done (either order, or the same cycle), go to WR_RESP.
- WR_RESP: `B_ready`=1. On `B_valid`, latch `B_resp`, go to DONE.
- DONE: pulse `req[grant_id]_done`. `rdata`/`resp` are presented that cycle and held until the next done for that requester. `rdata` is 0 for writes. Update `last_grant`, return to IDLE.
- AXI rules:
  - Valids never depend on ready.
  - Once asserted, a valid and its payload stay stable until the handshake.
  - Ready signals are asserted only in their own state.
- A requester must hold `reqN_valid` and its payload until `reqN_ready`. Deasserting earlier is permitted; the request is simply not taken.

## Timing
- Reset values: every output 0 (`W_strobe` is constant 4'b1111). FSM in IDLE, `last_grant`=1, so req0 wins the first contention.
- Read with zero-wait slave: ready at T0, AR handshake T1, R handshake T2, done T3.
- Write with zero-wait slave: ready at T0, AW+W handshake T1, B handshake T2, done T3.
- Next grant is no earlier than the cycle after done (IDLE at T4). Sustained throughput is 1 transaction per 4 cycles.
- Reset asserted mid-transaction abandons the transaction: all valids/readys drop the next edge and no done is issued. The slave is reset by the same `rst`.
- A request arriving during DONE waits for IDLE. There is no combinational path from `reqN_valid` to any AXI output.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter runs in RD_ADDR/RD_DATA/WR_ADDR/WR_RESP and resets in IDLE.
  - Reaching `TIMEOUT` cycles without completion drops all AXI valids/readys and forces DONE with resp=2'b10 (SLVERR) and rdata=0.
  - A late slave response is not accepted.
- Undefined: no counter; the FSM waits indefinitely for each handshake.

## Test plan
- Reset then req0 read addr 0x8, slave returns 0x0000_0004/OKAY with zero wait -> req0_ready at T0, AR_valid T1, req0_done T3 with rdata 0x4, resp 2'b00; `rst` mid-read -> all outputs 0 next cycle, no done.
- req1 write addr 0x4 data 0x41, slave delays W_ready 3 cycles after AW_ready -> AW_valid drops after its handshake, W_valid held with 0x41, req1_done with resp 00 after B.
- req0 and req1 both held valid for 4 transactions -> grants alternate 0,1,0,1, grant_id matches, no done lost.
- AR_ready and R_valid both high from T1 -> exactly one AR and one R handshake, rdata latched from the R handshake cycle.
- With `UART_ARB_TIMEOUT_EN`, TIMEOUT=8, slave never raises AR_ready -> AR_valid drops, done after 8 cycles with resp 2'b10, rdata 0; FSM then serves a pending req1.
